// File: rtl/rf_seq_pkg.sv
// Shared types and constants for the register-file command sequencer.
package rf_seq_pkg;

   typedef enum logic [2:0] {
      OP_CLR  = 3'b000,
      OP_LDI  = 3'b001,
      OP_INC  = 3'b010,
      OP_DEC  = 3'b011,
      OP_MOV  = 3'b100,
      OP_ADDK = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_GAP   = 2'd3
   } state_e;

   localparam logic [1:0] FS_CLR  = 2'b00;
   localparam logic [1:0] FS_LOAD = 2'b01;
   localparam logic [1:0] FS_DEC  = 2'b10;
   localparam logic [1:0] FS_INC  = 2'b11;

   localparam logic [2:0] IDX_T1 = 3'd0;
   localparam logic [2:0] IDX_T2 = 3'd1;
   localparam logic [2:0] IDX_T3 = 3'd2;
   localparam logic [2:0] IDX_T4 = 3'd3;
   localparam logic [2:0] IDX_R1 = 3'd4;
   localparam logic [2:0] IDX_R2 = 3'd5;
   localparam logic [2:0] IDX_R3 = 3'd6;
   localparam logic [2:0] IDX_R4 = 3'd7;

   function automatic logic op_is_defined(input logic [2:0] op);
      return (op <= OP_ADDK);
   endfunction

   function automatic logic [1:0] funsel_for(input logic [2:0] op);
      logic [1:0] fs;
      case (op)
         OP_CLR:         fs = FS_CLR;
         OP_LDI, OP_MOV: fs = FS_LOAD;
         OP_DEC:         fs = FS_DEC;
         default:        fs = FS_INC;
      endcase
      return fs;
   endfunction

endpackage

// File: rtl/rf_seq_sel_decode.sv
// Register index + enable to one-hot R/T write strobes (bit3 = R1/T1).
module rf_sel_decode
   import rf_seq_pkg::*;
(
   input  logic [2:0] i_idx,
   input  logic       i_en,
   output logic [3:0] o_rsel,
   output logic [3:0] o_tsel
);

   always_comb begin
      o_rsel = 4'b0000;
      o_tsel = 4'b0000;
      if (i_en) begin
         case (i_idx)
            IDX_T1: o_tsel = 4'b1000;
            IDX_T2: o_tsel = 4'b0100;
            IDX_T3: o_tsel = 4'b0010;
            IDX_T4: o_tsel = 4'b0001;
            IDX_R1: o_rsel = 4'b1000;
            IDX_R2: o_rsel = 4'b0100;
            IDX_R3: o_rsel = 4'b0010;
            IDX_R4: o_rsel = 4'b0001;
         endcase
      end
   end

endmodule

// File: rtl/rf_sequencer.sv
// Expands one register command into timed register-file select pulses.
// Optional undefined-opcode Error pulse: define RF_SEQ_ERR_CHK_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready, waiting for a command
// ST_READ  | MOV source on Output1, readback captured at end of cycle
// ST_WRITE | one write strobe to the destination register
// ST_GAP   | strobes low; repeats ADDK or finishes with Done
module rf_sequencer
   import rf_seq_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_cmd_valid,
   output logic       o_cmd_ready,
   input  logic [2:0] i_cmd_op,
   input  logic [2:0] i_cmd_dst,
   input  logic [2:0] i_cmd_src,
   input  logic [7:0] i_cmd_imm,
   input  logic [2:0] i_peek_sel,
   input  logic [7:0] i_rf_output1,
   output logic [3:0] o_rsel,
   output logic [3:0] o_tsel,
   output logic [1:0] o_funsel,
   output logic [2:0] o_o1sel,
   output logic [2:0] o_o2sel,
   output logic [7:0] o_rf_input,
   output logic       o_done,
   output logic       o_error
);

   state_e     r_state;
   state_e     w_state_nxt;
   logic [2:0] r_op;
   logic [2:0] r_dst;
   logic [7:0] r_cnt;
   logic [7:0] w_cnt_nxt;
   logic [7:0] r_data;
   logic [1:0] r_funsel;
   logic [2:0] r_o1sel;
   logic [2:0] r_o2sel;
   logic [3:0] r_rsel;
   logic [3:0] r_tsel;
   logic       r_done;
   logic       w_done_nxt;
   logic       w_accept;
   logic [2:0] w_dst;
   logic [3:0] w_rsel;
   logic [3:0] w_tsel;

   assign w_accept = i_cmd_valid && (r_state == ST_IDLE);
   assign w_dst    = w_accept ? i_cmd_dst : r_dst;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               case (i_cmd_op)
                  OP_CLR, OP_LDI, OP_INC, OP_DEC: w_state_nxt = ST_WRITE;
                  OP_MOV: w_state_nxt = ST_READ;
                  OP_ADDK: begin
                     w_cnt_nxt = i_cmd_imm;
                     if (i_cmd_imm == 8'd0) begin
                        w_state_nxt = ST_GAP;
                        w_done_nxt  = 1'b1;
                     end else begin
                        w_state_nxt = ST_WRITE;
                     end
                  end
                  default: begin
                     w_state_nxt = ST_GAP;
                     w_done_nxt  = 1'b1;
                  end
               endcase
            end
         end
         ST_READ:  w_state_nxt = ST_WRITE;
         ST_WRITE: begin
            w_state_nxt = ST_GAP;
            if (r_op == OP_ADDK) begin
               w_cnt_nxt  = r_cnt - 8'd1;
               w_done_nxt = (r_cnt == 8'd1);
            end else begin
               w_done_nxt = 1'b1;
            end
         end
         ST_GAP: begin
            if ((r_op == OP_ADDK) && (r_cnt != 8'd0))
               w_state_nxt = ST_WRITE;
            else
               w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Strobes are decoded from next state so they come out of a flop.
   rf_sel_decode u_sel_decode (
      .i_idx  (w_dst),
      .i_en   (w_state_nxt == ST_WRITE),
      .o_rsel (w_rsel),
      .o_tsel (w_tsel)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_op     <= 3'd0;
         r_dst    <= 3'd0;
         r_cnt    <= 8'd0;
         r_data   <= 8'd0;
         r_funsel <= FS_CLR;
         r_o1sel  <= 3'd0;
         r_o2sel  <= 3'd0;
         r_rsel   <= 4'd0;
         r_tsel   <= 4'd0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         r_rsel  <= w_rsel;
         r_tsel  <= w_tsel;
         r_o2sel <= i_peek_sel;
         if (w_accept) begin
            r_op  <= i_cmd_op;
            r_dst <= i_cmd_dst;
            if (op_is_defined(i_cmd_op))
               r_funsel <= funsel_for(i_cmd_op);
            if (i_cmd_op == OP_LDI)
               r_data <= i_cmd_imm;
            if (i_cmd_op == OP_MOV)
               r_o1sel <= i_cmd_src;
         end
         if (r_state == ST_READ)
            r_data <= i_rf_output1;
      end
   end

`ifdef RF_SEQ_ERR_CHK_EN
   logic r_err;
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_err <= 1'b0;
      else
         r_err <= w_accept && !op_is_defined(i_cmd_op);
   end
   assign o_error = r_err;
`else
   assign o_error = 1'b0;
`endif

   assign o_cmd_ready = (r_state == ST_IDLE);
   assign o_rsel      = r_rsel;
   assign o_tsel      = r_tsel;
   assign o_funsel    = r_funsel;
   assign o_o1sel     = r_o1sel;
   assign o_o2sel     = r_o2sel;
   assign o_rf_input  = r_data;
   assign o_done      = r_done;

endmodule
